// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH-channel PWM generator behind a byte-wide write port.
// Each channel has its own 8-bit duty. All channels share one prescaler and one
// programmable period. Duty, period and prescale writes land in shadow registers.
// The shadows move into the active set at a period wrap or on a forced commit,
// so a period that is already running never changes shape.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   wr_en        single-cycle write strobe
//   wr_addr      7-bit register address
//   wr_data      8-bit write data
//   out          NUM_CH PWM outputs (registered)
//   period_start one-cycle pulse marking the start of a period (registered)
module pwm_multichannel #(
    parameter int unsigned NUM_CH    = 16,
    parameter logic [7:0]  RESET_TOP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam logic [6:0] ADDR_OUT_EN_LO = 7'h00;
    localparam logic [6:0] ADDR_PWM_EN_LO = 7'h08;
    localparam logic [6:0] ADDR_PRESCALE  = 7'h10;
    localparam logic [6:0] ADDR_TOP       = 7'h11;
    localparam logic [6:0] ADDR_CTRL      = 7'h12;

    // Enables (not shadowed)
    logic [NUM_CH-1:0] out_en;
    logic [NUM_CH-1:0] pwm_en;

    // Shadow and active timing/duty registers
    logic [7:0] prescale_sh;
    logic [7:0] top_sh;
    logic [7:0] prescale;
    logic [7:0] top;
    logic [7:0] duty_sh [NUM_CH];
    logic [7:0] duty    [NUM_CH];

    // Counters
    logic [7:0] pre_cnt;
    logic [7:0] cnt;

    // A forced commit delays its period_start pulse by one clock. The pulse then
    // lines up with the first output of the restarted period.
    logic force_pend;

    // Combinational decode and timing events
    logic       force_commit_c;
    logic       tick_c;
    logic       wrap_c;
    logic       commit_c;
    logic       duty_wr_c;
    logic [5:0] duty_ch_c;

    assign force_commit_c = wr_en && (wr_addr == ADDR_CTRL) && wr_data[0];
    assign tick_c         = (pre_cnt == prescale);
    assign wrap_c         = tick_c && (cnt == top);
    assign commit_c       = wrap_c || force_commit_c;
    assign duty_ch_c      = wr_addr[5:0];
    assign duty_wr_c      = wr_en && wr_addr[6] && (32'(duty_ch_c) < NUM_CH);

    // Enable bytes: byte k of each bank covers channels 8k+7..8k. Bits beyond
    // NUM_CH have no storage, so writes to them are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en <= '0;
            pwm_en <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < NUM_CH; b++) begin
                if (wr_addr == ADDR_OUT_EN_LO + 7'(b / 8)) begin
                    out_en[b] <= wr_data[3'(b % 8)];
                end
                if (wr_addr == ADDR_PWM_EN_LO + 7'(b / 8)) begin
                    pwm_en[b] <= wr_data[3'(b % 8)];
                end
            end
        end
    end

    // Shadow period/prescale. A write that coincides with a wrap lands here only.
    // The commit in the same cycle takes the previous shadow value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_sh <= '0;
            top_sh      <= RESET_TOP;
        end else if (wr_en) begin
            if (wr_addr == ADDR_PRESCALE) begin
                prescale_sh <= wr_data;
            end
            if (wr_addr == ADDR_TOP) begin
                top_sh <= wr_data;
            end
        end
    end

    // Shadow duties, one per implemented channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                duty_sh[ch] <= '0;
            end
        end else if (duty_wr_c) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (duty_ch_c == 6'(ch)) begin
                    duty_sh[ch] <= wr_data;
                end
            end
        end
    end

    // Active set, loaded from the shadows on a wrap or a forced commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            top      <= RESET_TOP;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                duty[ch] <= '0;
            end
        end else if (commit_c) begin
            prescale <= prescale_sh;
            top      <= top_sh;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                duty[ch] <= duty_sh[ch];
            end
        end
    end

    // Prescaler and period counter; a forced commit restarts both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (force_commit_c) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick_c) begin
            pre_cnt <= '0;
            cnt     <= wrap_c ? 8'd0 : cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // Period-start pulse. A forced commit in the same cycle as a natural wrap
    // overrides the wrap, so only one pulse is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_pend   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            force_pend   <= force_commit_c;
            period_start <= (wrap_c && !force_commit_c) || force_pend;
        end
    end

    // Channel outputs. duty==FF forces high. duty==0 and duty>top fall out of
    // the compare naturally, because cnt never exceeds top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                out[ch] <= out_en[ch] &
                           (~pwm_en[ch] | (duty[ch] == 8'hFF) | (cnt < duty[ch]));
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: self-checking bench for pwm_multichannel (NUM_CH=20).
// A cycle-level reference model tracks each period as a clock-phase count and
// derives the counter value arithmetically. Table vectors and hand sequences
// measure duty and period on channel 0.
module tb_pwm_multichannel;

    localparam int unsigned NCH  = 20;
    localparam logic [7:0]  RTOP = 8'hFF;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [6:0]     wr_addr;
    logic [7:0]     wr_data;
    logic [NCH-1:0] out;
    logic           period_start;

    pwm_multichannel #(.NUM_CH(NCH), .RESET_TOP(RTOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit [NCH-1:0] m_oen, m_pen, m_out;
    int m_pre, m_top, m_pre_sh, m_top_sh, m_phase;
    int m_duty [NCH];
    int m_duty_sh [NCH];
    bit m_pend, m_ps;

    // Recorded channel-0 samples and the indices where period_start was seen
    bit rec_out[$];
    int rec_ps[$];

    typedef struct {
        int pre;
        int top;
        int duty;
        int pen;
        int exp_gap;
        int exp_high;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_oen = '0; m_pen = '0; m_out = '0;
        m_pre = 0; m_pre_sh = 0;
        m_top = int'(RTOP); m_top_sh = int'(RTOP);
        m_phase = 0; m_pend = 1'b0; m_ps = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_duty[c] = 0;
            m_duty_sh[c] = 0;
        end
    endfunction

    // One clock edge. Outputs come from the state before the edge. A commit
    // takes the shadows as they stood before this edge's write.
    function automatic void model_edge(input bit we, input int addr, input int data);
        int cnt, plen, idx;
        bit wrap, frc;
        cnt  = m_phase / (m_pre + 1);
        plen = (m_top + 1) * (m_pre + 1);
        wrap = (m_phase == plen - 1);
        frc  = we && (addr == 18) && ((data & 1) != 0);
        for (int c = 0; c < NCH; c++)
            m_out[c] = m_oen[c] && (!m_pen[c] || m_duty[c] == 255 || cnt < m_duty[c]);
        m_ps   = m_pend || (wrap && !frc);
        m_pend = frc;
        if (frc || wrap) begin
            m_pre = m_pre_sh;
            m_top = m_top_sh;
            for (int c = 0; c < NCH; c++) m_duty[c] = m_duty_sh[c];
            m_phase = 0;
        end else begin
            m_phase++;
        end
        if (we) begin
            if (addr < 16) begin
                for (int b = 0; b < 8; b++) begin
                    idx = (addr % 8) * 8 + b;
                    if (idx < NCH) begin
                        if (addr < 8) m_oen[idx] = ((data >> b) & 1) != 0;
                        else          m_pen[idx] = ((data >> b) & 1) != 0;
                    end
                end
            end else if (addr == 16) begin
                m_pre_sh = data;
            end else if (addr == 17) begin
                m_top_sh = data;
            end else if (addr >= 64 && addr - 64 < NCH) begin
                m_duty_sh[addr - 64] = data;
            end
        end
    endfunction

    task automatic step(input bit we, input int addr, input int data);
        wr_en   = we;
        wr_addr = 7'(addr);
        wr_data = 8'(data);
        @(posedge clk);
        model_edge(we, addr, data);
        @(negedge clk);
        wr_en = 1'b0;
        check("cycle", 64'({period_start, out}), 64'({m_ps, m_out}));
    endtask

    task automatic wr(input int addr, input int data);
        step(1'b1, addr, data);
    endtask

    task automatic record(input int n, input int wr_idx, input int addr, input int data);
        rec_out.delete();
        rec_ps.delete();
        for (int i = 0; i < n; i++) begin
            if (i == wr_idx) step(1'b1, addr, data);
            else             step(1'b0, 0, 0);
            rec_out.push_back(out[0]);
            if (period_start) rec_ps.push_back(i);
        end
    endtask

    function automatic int count_high(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < rec_out.size() && rec_out[i]) s++;
        return s;
    endfunction

    task automatic wait_ps(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1'b0, 0, 0);
            if (period_start) seen = 1'b1;
        end
        check("wait_period_start", 64'(seen), 64'd1);
    endtask

    task automatic reset_and_idle(input string tag);
        int hi_cnt = 0;
        rst = 1'b1;
        #1;
        check({tag, "_async_clear"}, 64'({period_start, out}), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check({tag, "_held"}, 64'({period_start, out}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 0, 0);
            if (out != '0) hi_cnt++;
        end
        check({tag, "_out_idle_600"}, 64'(hi_cnt), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, highs, first, second;

        //            pre  top    duty   pen gap  high
        vecs[0] = '{0, 8'hFF, 8'h80, 1, 256, 128};
        vecs[1] = '{0, 8'h3F, 8'h00, 1,  64,   0};
        vecs[2] = '{0, 8'hFF, 8'hFF, 1, 256, 256};
        vecs[3] = '{0, 8'h3F, 8'h50, 1,  64,  64};
        vecs[4] = '{0, 8'h3F, 8'h20, 0,  64,  64};
        vecs[5] = '{3, 9,     5,     1,  40,  20};
        vecs[6] = '{1, 4,     3,     1,  10,   6};
        vecs[7] = '{0, 8'h3F, 8'hFF, 1,  64,  64};

        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Power-on reset, then idle with all enables clear
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("por_outputs", 64'({period_start, out}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b0, 0, 0);
        reset_and_idle("reset_mid_period");

        // Table-driven duty/period vectors on channel 0
        wr(0, 1);
        for (int v = 0; v < 8; v++) begin
            wr(8, vecs[v].pen);
            wr(64, vecs[v].duty);
            wr(16, vecs[v].pre);
            wr(17, vecs[v].top);
            wr(18, 1);
            record((vecs[v].top + 1) * (vecs[v].pre + 1) * 3 + 8, -1, 0, 0);
            first  = (rec_ps.size() > 0) ? rec_ps[0] : -1;
            second = (rec_ps.size() > 1) ? rec_ps[1] : -1;
            if (rec_ps.size() >= 3) begin
                gap   = rec_ps[2] - rec_ps[1];
                highs = count_high(rec_ps[1], rec_ps[1] + gap - 1);
            end else begin
                gap   = -1;
                highs = -1;
            end
            check($sformatf("vec%0d_forced_pulse_idx", v), 64'(first), 64'(0));
            check($sformatf("vec%0d_first_wrap_idx", v), 64'(second), 64'(vecs[v].exp_gap - 1));
            check($sformatf("vec%0d_period", v), 64'(gap), 64'(vecs[v].exp_gap));
            check($sformatf("vec%0d_high_clks", v), 64'(highs), 64'(vecs[v].exp_high));
        end

        // Glitch-free duty update, mid-period and on the wrap cycle
        wr(8, 1); wr(64, 8'h80); wr(16, 0); wr(17, 8'hFF); wr(18, 1);
        step(1'b0, 0, 0);
        wait_ps(300);
        record(512, 8'h40, 8'h40, 8'h20);
        check("glitch_cur_period_high", 64'(count_high(0, 255)), 64'd128);
        check("glitch_high_at_7f", 64'(rec_out[127]), 64'd1);
        check("glitch_low_at_80", 64'(rec_out[128]), 64'd0);
        check("glitch_next_period_high", 64'(count_high(256, 511)), 64'd32);
        check("glitch_wrap_idx", 64'((rec_ps.size() > 0) ? rec_ps[0] : -1), 64'd255);
        record(768, 255, 8'h40, 8'h60);
        check("wrapwr_period0_high", 64'(count_high(0, 255)), 64'd32);
        check("wrapwr_period1_high", 64'(count_high(256, 511)), 64'd32);
        check("wrapwr_period2_high", 64'(count_high(512, 767)), 64'd96);
        check("wrapwr_pulse_count", 64'(rec_ps.size()), 64'd3);

        // Channel map with NUM_CH=20
        wr(0, 0); wr(1, 0); wr(8, 0); wr(9, 0); wr(10, 0);
        step(1'b0, 0, 0); step(1'b0, 0, 0);
        wr(2, 8'hFF);
        check("map_enable_latency", 64'(out), 64'd0);
        step(1'b0, 0, 0);
        check("map_out_19_16", 64'(out), 64'h000F_0000);
        wr(3, 8'hFF); wr(11, 8'hFF); wr(8'h54, 8'h00); wr(8'h13, 8'h55); wr(8'h7F, 8'h00);
        step(1'b0, 0, 0);
        check("map_unmapped_ignored", 64'(out), 64'h000F_0000);

        // Randomised traffic against the reference model
        wr(17, 12); wr(18, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 8))
                    0:       wr(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)));
                    1:       wr(8 + int'($urandom_range(0, 2)), int'($urandom_range(0, 255)));
                    2:       wr(16, int'($urandom_range(0, 3)));
                    3:       wr(17, int'($urandom_range(0, 24)));
                    4, 5:    wr(64 + int'($urandom_range(0, NCH + 3)), int'($urandom_range(0, 30)));
                    6:       wr(64 + int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)));
                    7:       wr(18, int'($urandom_range(0, 3)));
                    default: wr(int'($urandom_range(19, 63)), int'($urandom_range(0, 255)));
                endcase
            end else begin
                step(1'b0, 0, 0);
            end
        end

        // Reset while running with outputs active
        reset_and_idle("reset_after_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
